// File: rtl/sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one SRAM port between the instruction-fetch stage (IF) and the
// memory stage (MEM). Each granted access is a fixed WAIT_CYCLES-long SRAM
// transaction. It is followed by a one-cycle DONE state, in which the owner's
// ready output pulses.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   if_req / if_addr            fetch request and address
//   if_rdata / if_ready         fetched word (held) and completion pulse
//   mem_read / mem_write        data request controls (LDR / STR)
//   mem_addr / mem_wdata        data address and store data
//   mem_rdata / mem_ready       load word (held) and completion pulse
//   freeze                      pipeline stall while a MEM request is pending
//   sram_addr / sram_wdata      SRAM address and write data
//   sram_rdata                  SRAM read data
//   sram_cs_n/we_n/oe_n         SRAM strobes, active-low
//
// Optional build macro ARB_FAIRNESS_EN:
//   If MEM wins a grant while IF is also requesting, a starvation flag is set.
//   While that flag is set, the next idle grant goes to a pending IF request.
//   Without the macro, MEM always has priority over IF.
// ----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int unsigned      CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic       {OWN_IF, OWN_MEM}    owner_e;

  state_e              state_q;
  owner_e              owner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   mem_rdata_q;
  logic                if_ready_q;
  logic                mem_ready_q;
  logic                cs_n_q;
  logic                we_n_q;
  logic                oe_n_q;

  logic mem_req;
  logic grant_mem_d;
  logic grant_if_d;
  logic mem_is_write_d;

  assign mem_req        = mem_read | mem_write;
  // When both controls are high, the access is a write.
  assign mem_is_write_d = mem_write;

`ifdef ARB_FAIRNESS_EN
  logic if_starved_q;

  // A starved IF request takes the next grant ahead of MEM.
  assign grant_mem_d = mem_req & ~(if_starved_q & if_req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_starved_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (grant_mem_d && if_req) begin
        if_starved_q <= 1'b1;
      end else if (grant_if_d) begin
        if_starved_q <= 1'b0;
      end
    end
  end
`else
  assign grant_mem_d = mem_req;
`endif

  assign grant_if_d = if_req & ~grant_mem_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_mem_d || grant_if_d) begin
            owner_q <= grant_mem_d ? OWN_MEM : OWN_IF;
            addr_q  <= grant_mem_d ? mem_addr : if_addr;
            wdata_q <= mem_wdata;
            write_q <= grant_mem_d & mem_is_write_d;
            cnt_q   <= CNT_LOAD;
            // The strobes are registered, so they are loaded here. This way
            // they are active for exactly the WAIT_CYCLES cycles of ACCESS.
            cs_n_q  <= 1'b0;
            we_n_q  <= ~(grant_mem_d & mem_is_write_d);
            oe_n_q  <= grant_mem_d & mem_is_write_d;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (!write_q) begin
              if (owner_q == OWN_MEM) begin
                mem_rdata_q <= sram_rdata;
              end else begin
                if_rdata_q  <= sram_rdata;
              end
            end
            if (owner_q == OWN_MEM) begin
              mem_ready_q <= 1'b1;
            end else begin
              if_ready_q  <= 1'b1;
            end
            cs_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata   = if_rdata_q;
  assign if_ready   = if_ready_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_ready  = mem_ready_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_cs_n  = cs_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_oe_n  = oe_n_q;

  // This includes the cycles in which MEM waits behind an IF access.
  assign freeze = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int unsigned WAIT = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          freeze;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          sram_cs_n;
  logic          sram_we_n;
  logic          sram_oe_n;

  sram_port_arbiter #(
    .WAIT_CYCLES(WAIT),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .freeze    (freeze),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_cs_n (sram_cs_n),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM contents: a fixed table. The read data is valid only while the
  // chip is selected and the output enable is active.
  always_comb begin
    sram_rdata = 32'h0BAD0BAD;
    if (!sram_cs_n && !sram_oe_n) begin
      case (sram_addr)
        32'h0000_0010: sram_rdata = 32'hE3A00001;
        32'h0000_0014: sram_rdata = 32'hE2811001;
        32'h0000_0200: sram_rdata = 32'h12345678;
        32'h0000_0204: sram_rdata = 32'hCAFEF00D;
        default:       sram_rdata = 32'h0BAD0BAD;
      endcase
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          c;
    logic [31:0] d;
  } exp_t;

  exp_t ifq[$];
  exp_t memq[$];

  // Monitor: every ready pulse must match the next expected completion,
  // both in the cycle it occurs and in the data it returns.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (if_ready) begin
        if (ifq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL if_ready_spurious: got pulse at cycle %0d expected none", cyc);
        end else begin
          e = ifq.pop_front();
          chk("if_ready_cycle", cyc, e.c);
          chk("if_rdata", if_rdata, e.d);
        end
      end
      if (mem_ready) begin
        if (memq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL mem_ready_spurious: got pulse at cycle %0d expected none", cyc);
        end else begin
          e = memq.pop_front();
          chk("mem_ready_cycle", cyc, e.c);
          chk("mem_rdata", mem_rdata, e.d);
        end
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic wait_if_ready(input string name);
    int n = 0;
    while (!if_ready && n < 40) begin
      nxt();
      n++;
    end
    if (!if_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no if_ready within 40 cycles expected a pulse", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int k;
    rst       = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Values during reset
    nxt();
    chk("rst_if_ready",  if_ready,   0);
    chk("rst_mem_ready", mem_ready,  0);
    chk("rst_if_rdata",  if_rdata,   0);
    chk("rst_mem_rdata", mem_rdata,  0);
    chk("rst_cs_n",      sram_cs_n,  1);
    chk("rst_we_n",      sram_we_n,  1);
    chk("rst_oe_n",      sram_oe_n,  1);
    chk("rst_addr",      sram_addr,  0);
    chk("rst_wdata",     sram_wdata, 0);
    chk("rst_freeze",    freeze,     0);
    nxt();
    rst = 1'b1;
    nxt();

    // T1: IF read from address 0x10
    k = cyc;
    if_req  = 1'b1;
    if_addr = 32'h10;
    ifq.push_back('{k + 5, 32'hE3A00001});
    for (int i = 1; i <= 4; i++) begin
      nxt();
      chk("t1_cs_n", sram_cs_n, 0);
      chk("t1_oe_n", sram_oe_n, 0);
      chk("t1_we_n", sram_we_n, 1);
      chk("t1_addr", sram_addr, 32'h10);
    end
    nxt();
    chk("t1_cs_n_done", sram_cs_n, 1);
    chk("t1_oe_n_done", sram_oe_n, 1);
    if_req = 1'b0;
    nxt();

    // T2: MEM write to address 0x400. mem_rdata keeps its reset value.
    k = cyc;
    mem_write = 1'b1;
    mem_addr  = 32'h400;
    mem_wdata = 32'hDEADBEEF;
    #1 chk("t2_freeze_c0", freeze, 1);
    memq.push_back('{k + 5, 32'h0});
    for (int i = 1; i <= 4; i++) begin
      nxt();
      chk("t2_we_n",   sram_we_n,  0);
      chk("t2_oe_n",   sram_oe_n,  1);
      chk("t2_cs_n",   sram_cs_n,  0);
      chk("t2_addr",   sram_addr,  32'h400);
      chk("t2_wdata",  sram_wdata, 32'hDEADBEEF);
      chk("t2_freeze", freeze,     1);
    end
    nxt();
    #1 chk("t2_freeze_ready", freeze, 0);
    chk("t2_we_n_done", sram_we_n, 1);
    mem_write = 1'b0;
    nxt();

    // T3: IF and MEM request together. MEM is served first.
    k = cyc;
    if_req   = 1'b1;
    if_addr  = 32'h14;
    mem_read = 1'b1;
    mem_addr = 32'h200;
    memq.push_back('{k + 5, 32'h12345678});
    ifq.push_back('{k + 11, 32'hE2811001});
    for (int i = 1; i <= 4; i++) begin
      nxt();
      chk("t3_mem_addr", sram_addr, 32'h200);
      chk("t3_mem_oe_n", sram_oe_n, 0);
    end
    nxt();
    mem_read = 1'b0;
    nxt();
    chk("t3_idle_cs_n", sram_cs_n, 1);
    nxt();
    chk("t3_if_addr", sram_addr, 32'h14);
    chk("t3_if_cs_n", sram_cs_n, 0);
    chk("t3_if_oe_n", sram_oe_n, 0);
    wait_if_ready("t3_if_ready_wait");
    if_req = 1'b0;
    nxt();

    // T4: MEM read arrives during an IF access. freeze is held until mem_ready.
    k = cyc;
    if_req  = 1'b1;
    if_addr = 32'h10;
    ifq.push_back('{k + 5, 32'hE3A00001});
    nxt();
    #1 chk("t4_freeze_pre", freeze, 0);
    nxt();
    mem_read = 1'b1;
    mem_addr = 32'h204;
    memq.push_back('{k + 11, 32'hCAFEF00D});
    for (int i = 2; i <= 10; i++) begin
      #1 chk("t4_freeze", freeze, 1);
      if (i == 5) if_req = 1'b0;
      nxt();
    end
    #1 chk("t4_freeze_ready", freeze, 0);
    mem_read = 1'b0;
    nxt();

    // T5: reset in the middle of a read. The access is aborted with no ready pulse.
    k = cyc;
    if_req  = 1'b1;
    if_addr = 32'h10;
    nxt();
    nxt();
    chk("t5_cs_n_active", sram_cs_n, 0);
    rst = 1'b0;
    #1;
    chk("t5_cs_n_rst",   sram_cs_n, 1);
    chk("t5_oe_n_rst",   sram_oe_n, 1);
    chk("t5_we_n_rst",   sram_we_n, 1);
    chk("t5_addr_rst",   sram_addr, 0);
    chk("t5_if_rdata",   if_rdata,  0);
    chk("t5_mem_rdata",  mem_rdata, 0);
    chk("t5_if_ready",   if_ready,  0);
    if_req = 1'b0;
    nxt();
    rst = 1'b1;
    nxt();
    k = cyc;
    if_req  = 1'b1;
    if_addr = 32'h14;
    ifq.push_back('{k + 5, 32'hE2811001});
    wait_if_ready("t5_if_ready_wait");
    if_req = 1'b0;
    nxt();

    // T6: mem_read and mem_write both high. This is a write, so mem_rdata is not updated.
    k = cyc;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 32'h200;
    mem_wdata = 32'h55AA55AA;
    memq.push_back('{k + 5, 32'h0});
    for (int i = 1; i <= 4; i++) begin
      nxt();
      chk("t6_we_n",  sram_we_n,  0);
      chk("t6_oe_n",  sram_oe_n,  1);
      chk("t6_wdata", sram_wdata, 32'h55AA55AA);
    end
    nxt();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    nxt();
    chk("t6_if_rdata_hold", if_rdata, 32'hE2811001);

    // T7: MEM and IF both held for three access slots
    k = cyc;
    mem_read = 1'b1;
    mem_addr = 32'h204;
    if_req   = 1'b1;
    if_addr  = 32'h10;
`ifdef ARB_FAIRNESS_EN
    memq.push_back('{k + 5,  32'hCAFEF00D});
    ifq.push_back('{k + 11, 32'hE3A00001});
    memq.push_back('{k + 17, 32'hCAFEF00D});
`else
    memq.push_back('{k + 5,  32'hCAFEF00D});
    memq.push_back('{k + 11, 32'hCAFEF00D});
    memq.push_back('{k + 17, 32'hCAFEF00D});
`endif
    repeat (17) nxt();
    mem_read = 1'b0;
    if_req   = 1'b0;
    nxt();
    nxt();
`ifdef ARB_FAIRNESS_EN
    chk("t7_if_rdata", if_rdata, 32'hE3A00001);
`else
    chk("t7_if_rdata", if_rdata, 32'hE2811001);
`endif
    chk("t7_mem_rdata_hold", mem_rdata, 32'hCAFEF00D);

    repeat (3) nxt();
    chk("if_pending", ifq.size(), 0);
    chk("mem_pending", memq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Sequences the single shared SRAM port between the instruction-fetch stage and the memory stage.
- MEM-stage requests come from the decoded mem_read/mem_write controls (LDR/STR); IF requests come from the PC fetch.
- Every access is a fixed multi-cycle SRAM transaction. The block returns one-cycle ready pulses and a freeze signal that stalls the pipeline while a data access is outstanding.

Parameters:
- WAIT_CYCLES, 4, SRAM access length in cycles; legal values are ≥1.
- ADDR_W, 32, address width for requesters and SRAM.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- mem_read  in  1  data read request (LDR).
- mem_write  in  1  data write request (STR).
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; valid while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse for MEM.
- freeze  out  1  pipeline stall request.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data.
- sram_cs_n  out  1  chip select, active-low.
- sram_we_n  out  1  write enable, active-low.
- sram_oe_n  out  1  output enable, active-low.

Behaviour:
- Reset (async, rst=0):
  - State goes to IDLE; counter=0; owner=IF.
  - if_ready=0, mem_ready=0; if_rdata=0, mem_rdata=0.
  - sram_cs_n=sram_we_n=sram_oe_n=1; sram_addr=0, sram_wdata=0.
  - A reset mid-access aborts the access. No ready pulse is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If mem_read|mem_write, grant MEM. Otherwise if if_req, grant IF. Otherwise stay in IDLE.
  - On a grant, latch owner, address, write data and direction (write=mem_write). Load counter=WAIT_CYCLES-1. Go to ACCESS.
  - mem_read and mem_write both high is treated as a write; mem_rdata is not updated.
- ACCESS:
  - sram_cs_n=0. For writes, sram_we_n=0 and sram_oe_n=1; for reads, sram_oe_n=0 and sram_we_n=1.
  - sram_addr and sram_wdata come from the latched values.
  - Counter decrements each cycle. When counter==0: for a read, register sram_rdata into the owner's rdata register; go to DONE.
- DONE:
  - SRAM controls are inactive. The owner's ready pulses high for exactly one cycle. Go to IDLE.
  - Requests are ignored in DONE.
- Latency: a request seen in IDLE at cycle 0 gives ACCESS in cycles 1..WAIT_CYCLES and ready in cycle WAIT_CYCLES+1.
- Back-to-back accesses: the earliest next grant is the cycle after DONE, so throughput is one access per WAIT_CYCLES+2 cycles.
- Requester rules:
  - Inputs are held stable until the ready pulse.
  - A request still asserted in the cycle after ready is a new request.
  - A request withdrawn mid-access does not cancel it; the access completes and ready still pulses.
- Data hold: if_rdata and mem_rdata hold their value until the next read by the same owner.
- freeze = (mem_read|mem_write) & ~mem_ready. This is combinational and includes cycles where MEM is waiting behind an IF access. IF waits are signalled only via if_ready.
- Priority without the optional feature: fixed, MEM over IF.
- Width rules: the counter is wide enough to hold WAIT_CYCLES-1. There is no address arithmetic; addresses pass through unchanged.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Defined:
  - A 1-bit flag `if_starved` sets when MEM is granted while if_req=1.
  - In IDLE with if_starved=1 and if_req=1, IF is granted even if MEM requests. The flag clears on any IF grant.
  - Reset clears the flag.
- Undefined: strict MEM-over-IF priority and no extra state.

Test Plan:
- WAIT_CYCLES=4; if_req=1, if_addr=0x10, sram_rdata=0xE3A00001 → sram_oe_n=0 for cycles 1-4; if_ready=1 at cycle 5 only; if_rdata=0xE3A00001.
- mem_write=1, mem_addr=0x400, mem_wdata=0xDEADBEEF → sram_we_n=0 for 4 cycles with sram_addr=0x400 and sram_wdata=0xDEADBEEF; freeze=1 in cycles 0-4; mem_ready pulse at cycle 5; freeze=0 at cycle 5.
- if_req and mem_read asserted together in IDLE → MEM served first (mem_ready at cycle 5); IF granted at cycle 6; if_ready at cycle 11.
- mem_read asserted at cycle 2 during an IF access → IF completes (if_ready at cycle 5); freeze=1 from cycle 2 until mem_ready at cycle 11.
- rst=0 at cycle 2 of a read → all SRAM controls high immediately; no ready pulse; after release, a new if_req completes normally in 5 cycles.
- ARB_FAIRNESS_EN defined; mem_read and if_req both held continuously → grants alternate MEM, IF, MEM, IF; undefined → MEM only.
